// File: rtl/servo_pwm_decoder_pkg.sv
// Servo PWM definitions shared by the PWM generator and this decoder: the instruction
// encoding, the default timing thresholds and the pulse-width classifier.
package servo_pwm_decoder_pkg;

    typedef enum logic [1:0] {
        SERVO_REST  = 2'b00,
        SERVO_LEFT  = 2'b01,
        SERVO_RIGHT = 2'b10,
        SERVO_FAULT = 2'b11
    } servo_instr_e;

    typedef enum logic [1:0] {
        ST_ARM,
        ST_LOW,
        ST_HIGH
    } dec_state_e;

    localparam int unsigned DEF_CLKS_PER_US = 100;
    localparam int unsigned DEF_MIN_US      = 900;
    localparam int unsigned DEF_REST_LO_US  = 1400;
    localparam int unsigned DEF_REST_HI_US  = 1600;
    localparam int unsigned DEF_MAX_US      = 2100;
    localparam int unsigned DEF_TIMEOUT_US  = 25000;

    localparam int WIDTH_BITS = 12;
    localparam int WDOG_BITS  = 15;

    // Legal widths map to left / rest / right; anything outside [min_us, max_us] is a fault.
    function automatic servo_instr_e classify(
        input logic [WIDTH_BITS-1:0] w,
        input logic [WIDTH_BITS-1:0] min_us,
        input logic [WIDTH_BITS-1:0] lo_us,
        input logic [WIDTH_BITS-1:0] hi_us,
        input logic [WIDTH_BITS-1:0] max_us
    );
        if (w < min_us || w > max_us) return SERVO_FAULT;
        if (w < lo_us)                return SERVO_LEFT;
        if (w <= hi_us)               return SERVO_REST;
        return SERVO_RIGHT;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus delay register for an asynchronous level input, with
// registered rise/fall strobes aligned to the delayed level.
module sync_edge (
    input  logic clk,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic s;
    logic d;

    // NOTE: the synchronizer is deliberately not reset, so right after reset it already
    // shows the true line level and a pulse in progress cannot masquerade as a new rise.
    // NOTE: non-blocking assignments make every flop sample the pre-edge values.
    always_ff @(posedge clk) begin
        meta <= raw;
        s    <= meta;
        d    <= s;
        rise <= s & ~d;
        fall <= ~s & d;
    end

    // d carries the same delay as the strobes, so rise implies level = 1.
    assign level = d;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Measures the high time of a hobby-servo PWM pulse and decodes it into a rest/left/right
// instruction, flagging out-of-range pulses and a lost signal.
module servo_pwm_decoder
    import servo_pwm_decoder_pkg::*;
#(
    parameter int unsigned CLKS_PER_US = DEF_CLKS_PER_US,
    parameter int unsigned MIN_US      = DEF_MIN_US,
    parameter int unsigned REST_LO_US  = DEF_REST_LO_US,
    parameter int unsigned REST_HI_US  = DEF_REST_HI_US,
    parameter int unsigned MAX_US      = DEF_MAX_US,
    parameter int unsigned TIMEOUT_US  = DEF_TIMEOUT_US
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pwm_in,
    output logic [1:0]            servo_instruction,
    output logic [WIDTH_BITS-1:0] width_us,
    output logic                  pulse_valid,
    output logic                  pulse_err,
    output logic                  timeout
);

    localparam int PRE_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

    localparam logic [PRE_W-1:0]      PRE_LAST   = PRE_W'(CLKS_PER_US - 1);
    localparam logic [PRE_W-1:0]      PRE_ONE    = PRE_W'(1);
    localparam logic [WIDTH_BITS-1:0] WIDTH_MAX  = '1;
    localparam logic [WIDTH_BITS-1:0] WIDTH_ONE  = WIDTH_BITS'(1);
    localparam logic [WIDTH_BITS-1:0] MIN_W      = WIDTH_BITS'(MIN_US);
    localparam logic [WIDTH_BITS-1:0] REST_LO_W  = WIDTH_BITS'(REST_LO_US);
    localparam logic [WIDTH_BITS-1:0] REST_HI_W  = WIDTH_BITS'(REST_HI_US);
    localparam logic [WIDTH_BITS-1:0] MAX_W      = WIDTH_BITS'(MAX_US);
    localparam logic [WDOG_BITS-1:0]  WDOG_LIMIT = WDOG_BITS'(TIMEOUT_US);
    localparam logic [WDOG_BITS-1:0]  WDOG_ONE   = WDOG_BITS'(1);

    logic level;
    logic rise;
    logic fall;

    sync_edge u_sync (
        .clk   (clk),
        .raw   (pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    dec_state_e            state, state_next;
    logic [PRE_W-1:0]      pre, pre_next, pre_inc;
    logic [WIDTH_BITS-1:0] width, width_next, width_inc;
    logic [PRE_W-1:0]      wd_pre, wd_pre_next;
    logic [WDOG_BITS-1:0]  wd, wd_next;
    servo_instr_e          instr_next, pulse_instr;
    logic [WIDTH_BITS-1:0] width_us_next;
    logic                  valid_next;
    logic                  err_next;
    logic                  timeout_next;

    // The width count including the current cycle; a fall uses it so the falling cycle counts.
    always_comb begin
        if (pre == PRE_LAST) begin
            pre_inc   = '0;
            width_inc = (width == WIDTH_MAX) ? width : width + WIDTH_ONE;
        end else begin
            pre_inc   = pre + PRE_ONE;
            width_inc = width;
        end
    end

    assign pulse_instr = classify(width_inc, MIN_W, REST_LO_W, REST_HI_W, MAX_W);

    // NOTE: every signal gets its hold value first, so no path through this block infers a latch.
    always_comb begin
        state_next    = state;
        pre_next      = pre;
        width_next    = width;
        wd_pre_next   = wd_pre;
        wd_next       = wd;
        instr_next    = servo_instr_e'(servo_instruction);
        width_us_next = width_us;
        valid_next    = 1'b0;
        err_next      = pulse_err;
        timeout_next  = timeout;

        if (rise) begin
            wd_pre_next = '0;
            wd_next     = '0;
        end else if (wd != WDOG_LIMIT) begin
            if (wd_pre == PRE_LAST) begin
                wd_pre_next = '0;
                wd_next     = wd + WDOG_ONE;
            end else begin
                wd_pre_next = wd_pre + PRE_ONE;
            end
        end

        // A lost signal decodes as rest; a fall in the same cycle overrides below.
        if (wd != WDOG_LIMIT && wd_next == WDOG_LIMIT) begin
            timeout_next = 1'b1;
            instr_next   = SERVO_REST;
        end

        case (state)
            ST_ARM: begin
                if (!level) state_next = ST_LOW;
            end
            ST_LOW: begin
                if (rise) begin
                    pre_next   = '0;
                    width_next = '0;
                    state_next = ST_HIGH;
                end
            end
            ST_HIGH: begin
                pre_next   = pre_inc;
                width_next = width_inc;
                if (fall) begin
                    state_next    = ST_LOW;
                    valid_next    = 1'b1;
                    width_us_next = width_inc;
                    instr_next    = pulse_instr;
                    err_next      = (pulse_instr == SERVO_FAULT);
                    if (pulse_instr != SERVO_FAULT) timeout_next = 1'b0;
                end
            end
            default: state_next = ST_ARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_ARM;
            pre               <= '0;
            width             <= '0;
            wd_pre            <= '0;
            wd                <= '0;
            servo_instruction <= SERVO_REST;
            width_us          <= '0;
            pulse_valid       <= 1'b0;
            pulse_err         <= 1'b0;
            timeout           <= 1'b1;
        end else begin
            state             <= state_next;
            pre               <= pre_next;
            width             <= width_next;
            wd_pre            <= wd_pre_next;
            wd                <= wd_next;
            servo_instruction <= instr_next;
            width_us          <= width_us_next;
            pulse_valid       <= valid_next;
            pulse_err         <= err_next;
            timeout           <= timeout_next;
        end
    end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Self-checking bench for servo_pwm_decoder: an event-level reference model compared every
// cycle, plus literal expectations for band edges, signal loss, stuck-high and reset cases.
module tb_servo_pwm_decoder;

    // Scaled clock and watchdog keep the run short; the µs thresholds stay at their defaults.
    localparam int CLKS    = 2;
    localparam int TO_US   = 2500;
    localparam int TO_CYC  = CLKS * TO_US;
    localparam int LATENCY = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwm_in = 1'b1;
    logic [1:0]  servo_instruction;
    logic [11:0] width_us;
    logic        pulse_valid;
    logic        pulse_err;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int cyc      = 0;

    servo_pwm_decoder #(
        .CLKS_PER_US (CLKS),
        .TIMEOUT_US  (TO_US)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .pwm_in            (pwm_in),
        .servo_instruction (servo_instruction),
        .width_us          (width_us),
        .pulse_valid       (pulse_valid),
        .pulse_err         (pulse_err),
        .timeout           (timeout)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic logic [1:0] expect_instr(input int w);
        if (w < 900 || w > 2100) return 2'b11;
        if (w < 1400)            return 2'b01;
        if (w <= 1600)           return 2'b00;
        return 2'b10;
    endfunction

    // Reference model: outputs react LATENCY edges after the edge that sampled an input
    // transition; width is elapsed cycles between rise and fall divided by CLKS.
    logic [4:0]  hist = '0;
    bit          model_live = 1'b0;
    bit          armed = 1'b0;
    bit          in_pulse = 1'b0;
    int          rise_edge = 0;
    int          clear_edge = 0;
    logic [1:0]  exp_instr = 2'b00;
    logic [11:0] exp_width = '0;
    bit          exp_valid = 1'b0;
    bit          exp_err = 1'b0;
    bit          exp_timeout = 1'b1;

    initial forever begin
        bit d_rise;
        bit d_fall;
        int w;
        @(posedge clk);
        cyc++;
        hist = {hist[3:0], pwm_in};
        exp_valid = 1'b0;
        if (rst) begin
            model_live  = 1'b1;
            armed       = 1'b0;
            in_pulse    = 1'b0;
            clear_edge  = cyc;
            exp_instr   = 2'b00;
            exp_width   = '0;
            exp_err     = 1'b0;
            exp_timeout = 1'b1;
        end else if (model_live) begin
            d_rise = hist[LATENCY] && !hist[LATENCY+1];
            d_fall = !hist[LATENCY] && hist[LATENCY+1];
            if (d_rise) begin
                clear_edge = cyc;
            end else if (cyc - clear_edge == TO_CYC) begin
                exp_timeout = 1'b1;
                exp_instr   = 2'b00;
            end
            if (in_pulse && d_fall) begin
                w = (cyc - rise_edge) / CLKS;
                if (w > 4095) w = 4095;
                exp_valid = 1'b1;
                exp_width = 12'(w);
                exp_instr = expect_instr(w);
                exp_err   = (exp_instr == 2'b11);
                if (!exp_err) exp_timeout = 1'b0;
                in_pulse = 1'b0;
            end
            if (armed && !in_pulse && d_rise) begin
                in_pulse  = 1'b1;
                rise_edge = cyc;
            end
            if (!hist[LATENCY]) armed = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (model_live) begin
            if (pulse_valid) n_valid++;
            check("model_pulse_valid", 32'(pulse_valid), 32'(exp_valid));
            check("model_instruction", 32'(servo_instruction), 32'(exp_instr));
            check("model_width_us", 32'(width_us), 32'(exp_width));
            check("model_pulse_err", 32'(pulse_err), 32'(exp_err));
            check("model_timeout", 32'(timeout), 32'(exp_timeout));
        end
    end

    task automatic drive_pulse(input int hi, input int lo);
        pwm_in = 1'b1;
        repeat (hi) @(negedge clk);
        pwm_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    // Drives one pulse, waits a bounded time for its report and checks literal values.
    task automatic pulse_expect(input string tag, input int hi, input int w,
                                input logic [1:0] ins, input bit err, input bit to);
        bit seen = 1'b0;
        pwm_in = 1'b1;
        repeat (hi) @(negedge clk);
        pwm_in = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (pulse_valid) seen = 1'b1;
        end
        check({tag, "_valid_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_width"}, 32'(width_us), w);
            check({tag, "_instr"}, 32'(servo_instruction), 32'(ins));
            check({tag, "_err"}, 32'(pulse_err), 32'(err));
            check({tag, "_timeout"}, 32'(timeout), 32'(to));
        end
        repeat (100) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_instr"}, 32'(servo_instruction), 32'd0);
        check({tag, "_width"}, 32'(width_us), 32'd0);
        check({tag, "_valid"}, 32'(pulse_valid), 32'd0);
        check({tag, "_err"}, 32'(pulse_err), 32'd0);
        check({tag, "_timeout"}, 32'(timeout), 32'd1);
    endtask

    typedef struct {
        int         hi;
        int         w;
        logic [1:0] ins;
        bit         err;
    } band_t;

    band_t band [8] = '{
        '{2799, 1399, 2'b01, 1'b0},
        '{2800, 1400, 2'b00, 1'b0},
        '{3201, 1600, 2'b00, 1'b0},
        '{3202, 1601, 2'b10, 1'b0},
        '{1800,  900, 2'b01, 1'b0},
        '{1799,  899, 2'b11, 1'b1},
        '{4200, 2100, 2'b10, 1'b0},
        '{4202, 2101, 2'b11, 1'b1}
    };

    initial begin
        int nv;

        // Reset released while the line is already high: that pulse is never reported.
        repeat (6) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        repeat (1000) @(negedge clk);
        pwm_in = 1'b0;
        repeat (100) @(negedge clk);
        check("startup_pulse_dropped", 32'(n_valid), 32'd0);

        pulse_expect("rest_1500", 3000, 1500, 2'b00, 1'b0, 1'b0);
        pulse_expect("left_1000", 2000, 1000, 2'b01, 1'b0, 1'b0);
        pulse_expect("right_2000", 4000, 2000, 2'b10, 1'b0, 1'b0);

        foreach (band[i])
            pulse_expect($sformatf("band_%0d", band[i].w), band[i].hi, band[i].w,
                         band[i].ins, band[i].err, 1'b0);

        // Signal loss: timeout exactly TO_US after the last rise, width held.
        pulse_expect("loss_pre", 4000, 2000, 2'b10, 1'b0, 1'b0);
        pwm_in = 1'b1;
        for (int j = 1; j <= 5600; j++) begin
            @(negedge clk);
            if (j == 4000) pwm_in = 1'b0;
            if (j == TO_CYC + LATENCY) check("loss_timeout_not_yet", 32'(timeout), 32'd0);
            if (j == TO_CYC + LATENCY + 1) begin
                check("loss_timeout", 32'(timeout), 32'd1);
                check("loss_instr_rest", 32'(servo_instruction), 32'd0);
                check("loss_width_held", 32'(width_us), 32'd2000);
            end
        end
        pulse_expect("loss_recover", 3000, 1500, 2'b00, 1'b0, 1'b0);

        // Stuck high: timeout while high, single saturated fault report on release.
        nv = n_valid;
        pulse_expect("stuck_high", 8300, 4095, 2'b11, 1'b1, 1'b1);
        check("stuck_single_report", 32'(n_valid), 32'(nv + 1));
        pulse_expect("stuck_recover", 2000, 1000, 2'b01, 1'b0, 1'b0);

        // One-cycle reset in the middle of a 1500 us pulse.
        nv = n_valid;
        pwm_in = 1'b1;
        repeat (1000) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midpulse_reset");
        rst = 1'b0;
        repeat (2000) @(negedge clk);
        pwm_in = 1'b0;
        repeat (100) @(negedge clk);
        check("midpulse_dropped", 32'(n_valid), 32'(nv));
        pulse_expect("after_reset", 3000, 1500, 2'b00, 1'b0, 1'b0);

        // Random pulse widths and gaps, checked by the model alone.
        for (int k = 0; k < 2; k++)
            drive_pulse(int'($urandom_range(850, 2150)) * CLKS + int'($urandom_range(0, CLKS - 1)),
                        int'($urandom_range(20, 400)));

        repeat (20) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
